// File: rtl/multiaddr_decode_stream_pkg.sv
// Shared types for the multicast address decoder: FSM state and the default
// address/rule types used when the parent does not override them.
package multiaddr_decode_stream_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StEmit,
    StErr
  } state_e;

  typedef logic [7:0] addr_default_t;

  typedef struct packed {
    int unsigned   idx;
    addr_default_t addr;
    addr_default_t mask;
  } rule_default_t;

endpackage

// File: rtl/multiaddr_decode_stream_lzc.sv
// Trailing-zero counter: index of the lowest set bit of in_i; empty_o when in_i is zero.
module multiaddr_decode_stream_lzc #(
  parameter int unsigned Width    = 4,
  parameter int unsigned CntWidth = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0]    in_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                empty_o
);

  // Scan from the top down so the lowest set bit is written last and wins.
  always_comb begin
    cnt_o   = '0;
    empty_o = 1'b1;
    for (int i = Width - 1; i >= 0; i--) begin
      if (in_i[i]) begin
        cnt_o   = CntWidth'(i);
        empty_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/multiaddr_decode_stream.sv
// Sequential multicast decoder: accepts one {addr, mask} request, matches it against
// the rule map and emits one beat per selected destination index, lowest index first.
module multiaddr_decode_stream
  import multiaddr_decode_stream_pkg::*;
#(
  parameter int unsigned NoIndices = 4,
  parameter int unsigned NoRules   = 4,
  parameter type         addr_t    = addr_default_t,
  parameter type         rule_t    = rule_default_t,
  localparam int unsigned IdxWidth = (NoIndices > 1) ? $clog2(NoIndices) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  rule_t [NoRules-1:0]   addr_map_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  addr_t                 addr_i,
  input  addr_t                 mask_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [IdxWidth-1:0]   idx_o,
  output addr_t                 addr_o,
  output addr_t                 mask_o,
  output logic                  last_o,
  output logic                  error_o,
  output logic [NoIndices-1:0]  select_o
);

  state_e                 state_q;
  logic [NoIndices-1:0]   pending_q, select_q, sel_d;
  addr_t                  addr_q [NoIndices];
  addr_t                  mask_q [NoIndices];
  addr_t                  dec_addr [NoIndices];
  addr_t                  dec_mask [NoIndices];
  logic [IdxWidth-1:0]    first_idx;
  logic                   pending_empty;
  logic                   one_left;
  logic                   accept;
  logic                   beat_done;

  // Decode the request against every rule; a later matching rule overrides addr/mask.
  always_comb begin
    sel_d = '0;
    for (int unsigned k = 0; k < NoIndices; k++) begin
      dec_addr[k] = '0;
      dec_mask[k] = '0;
    end
    for (int unsigned i = 0; i < NoRules; i++) begin
      if (&(mask_i | addr_map_i[i].mask | ~(addr_i ^ addr_map_i[i].addr))) begin
        for (int unsigned k = 0; k < NoIndices; k++) begin
          if (addr_map_i[i].idx == k) begin
            sel_d[k]    = 1'b1;
            dec_addr[k] = (~mask_i & addr_i) | (mask_i & addr_map_i[i].addr);
            dec_mask[k] = mask_i & addr_map_i[i].mask;
          end
        end
      end
    end
  end

  multiaddr_decode_stream_lzc #(
    .Width    (NoIndices),
    .CntWidth (IdxWidth)
  ) u_lzc (
    .in_i    (pending_q),
    .cnt_o   (first_idx),
    .empty_o (pending_empty)
  );

  // Beat outputs are driven purely from registered state; only ready_o sees ready_i.
  always_comb begin
    one_left  = !pending_empty && ((pending_q & (pending_q - NoIndices'(1))) == '0);
    valid_o   = (state_q != StIdle);
    idx_o     = valid_o ? first_idx : '0;
    addr_o    = valid_o ? addr_q[first_idx] : '0;
    mask_o    = valid_o ? mask_q[first_idx] : '0;
    last_o    = valid_o && one_left;
    error_o   = (state_q == StErr);
    select_o  = select_q;
    ready_o   = (state_q == StIdle) || (valid_o && ready_i && last_o);
    accept    = valid_i && ready_o;
    beat_done = valid_o && ready_i;
  end

  // FSM and payload storage; the error beat reuses slot 0 with pending = 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pending_q <= '0;
      select_q  <= '0;
      for (int unsigned k = 0; k < NoIndices; k++) begin
        addr_q[k] <= '0;
        mask_q[k] <= '0;
      end
    end else begin
      if (beat_done) begin
        pending_q <= pending_q & ~(NoIndices'(1) << first_idx);
        if (last_o) begin
          state_q  <= StIdle;
          select_q <= '0;
        end
      end
      // A new acceptance on the last beat overrides the return to idle.
      if (accept) begin
        if (sel_d == '0) begin
          state_q   <= StErr;
          pending_q <= NoIndices'(1);
          select_q  <= '0;
          addr_q[0] <= addr_i;
          mask_q[0] <= mask_i;
        end else begin
          state_q   <= StEmit;
          pending_q <= sel_d;
          select_q  <= sel_d;
          for (int unsigned k = 0; k < NoIndices; k++) begin
            addr_q[k] <= dec_addr[k];
            mask_q[k] <= dec_mask[k];
          end
        end
      end
    end
  end

`ifndef SYNTHESIS
  if (NoIndices == 0 || NoRules == 0) begin : gen_bad_params
    $error("NoIndices and NoRules must be greater than zero");
  end

  // Rule indices must address a real destination whenever the map is sampled.
  always_ff @(posedge clk_i) begin
    if (!rst_i && accept) begin
      for (int unsigned i = 0; i < NoRules; i++) begin
        assert (addr_map_i[i].idx < NoIndices)
          else $error("rule %0d idx %0d out of range", i, addr_map_i[i].idx);
      end
    end
  end

  stable_under_backpressure: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_o && !ready_i) |=> (valid_o && $stable(idx_o) && $stable(addr_o) &&
                               $stable(mask_o) && $stable(last_o) && $stable(error_o)));
`endif

endmodule

// File: tb/tb_multiaddr_decode_stream.sv
// Directed bench for multiaddr_decode_stream with the four-rule 8-bit map.
module tb_multiaddr_decode_stream;
  import multiaddr_decode_stream_pkg::*;

  logic                 clk;
  logic                 rst_i;
  rule_default_t [3:0]  addr_map;
  logic                 valid_i;
  logic                 ready_o;
  logic [7:0]           addr_i;
  logic [7:0]           mask_i;
  logic                 valid_o;
  logic                 ready_i;
  logic [1:0]           idx_o;
  logic [7:0]           addr_o;
  logic [7:0]           mask_o;
  logic                 last_o;
  logic                 error_o;
  logic [3:0]           select_o;

  int tests;
  int fails;

  multiaddr_decode_stream #(
    .NoIndices (4),
    .NoRules   (4),
    .addr_t    (addr_default_t),
    .rule_t    (rule_default_t)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .addr_map_i (addr_map),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .addr_i     (addr_i),
    .mask_i     (mask_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .idx_o      (idx_o),
    .addr_o     (addr_o),
    .mask_o     (mask_o),
    .last_o     (last_o),
    .error_o    (error_o),
    .select_o   (select_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    addr_i  = '0;
    mask_i  = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    tests++;
    if ({valid_o, ready_o, last_o, error_o} !== 4'b0100) begin
      fails++;
      $display("FAIL reset_ctrl: got v/r/l/e=%b, want 0100", {valid_o, ready_o, last_o, error_o});
    end
    tests++;
    if ({select_o, idx_o, addr_o, mask_o} !== 22'h0) begin
      fails++;
      $display("FAIL reset_data: got sel=%b idx=%0d addr=%h mask=%h, want all zero",
               select_o, idx_o, addr_o, mask_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_unicast();
    valid_i = 1'b1; addr_i = 8'h15; mask_i = 8'h00; ready_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    tests++;
    if ({valid_o, idx_o, addr_o, mask_o, last_o, error_o} !== {1'b1, 2'd1, 8'h15, 8'h00, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL unicast_beat: got v=%b idx=%0d addr=%h mask=%h last=%b err=%b, want 1 1 15 00 1 0",
               valid_o, idx_o, addr_o, mask_o, last_o, error_o);
    end
    tests++;
    if (select_o !== 4'b0010) begin
      fails++;
      $display("FAIL unicast_select: got %b, want 0010", select_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({valid_o, ready_o, select_o} !== {1'b0, 1'b1, 4'b0000}) begin
      fails++;
      $display("FAIL unicast_idle: got v=%b r=%b sel=%b, want 0 1 0000", valid_o, ready_o, select_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_multicast();
    logic [1:0] exp_idx  [3] = '{2'd0, 2'd1, 2'd2};
    logic [7:0] exp_addr [3] = '{8'h00, 8'h10, 8'h20};
    logic [7:0] exp_mask [3] = '{8'h00, 8'h00, 8'h10};
    valid_i = 1'b1; addr_i = 8'h00; mask_i = 8'h30; ready_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      tests++;
      if ({valid_o, idx_o, addr_o, mask_o, last_o, error_o, ready_o} !==
          {1'b1, exp_idx[b], exp_addr[b], exp_mask[b], b == 2, 1'b0, b == 2}) begin
        fails++;
        $display("FAIL multicast_beat%0d: got v=%b idx=%0d addr=%h mask=%h last=%b err=%b rdy=%b, want 1 %0d %h %h %b 0 %b",
                 b, valid_o, idx_o, addr_o, mask_o, last_o, error_o, ready_o,
                 exp_idx[b], exp_addr[b], exp_mask[b], b == 2, b == 2);
      end
      tests++;
      if (select_o !== 4'b0111) begin
        fails++;
        $display("FAIL multicast_select%0d: got %b, want 0111", b, select_o);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    tests++;
    if (valid_o !== 1'b0) begin
      fails++;
      $display("FAIL multicast_end: got valid=%b, want 0", valid_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int beats = 0;
    valid_i = 1'b1; addr_i = 8'h00; mask_i = 8'h30; ready_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      ready_i = !(c >= 1 && c <= 3);
      @(negedge clk);
      if (valid_o && ready_i) beats++;
      if (c >= 1 && c <= 4) begin
        tests++;
        if ({valid_o, idx_o, addr_o, mask_o, last_o, error_o} !==
            {1'b1, 2'd1, 8'h10, 8'h00, 1'b0, 1'b0}) begin
          fails++;
          $display("FAIL backpressure_hold%0d: got v=%b idx=%0d addr=%h mask=%h last=%b err=%b, want 1 1 10 00 0 0",
                   c, valid_o, idx_o, addr_o, mask_o, last_o, error_o);
        end
      end
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    tests++;
    if (beats !== 3) begin
      fails++;
      $display("FAIL backpressure_count: got %0d beats, want 3", beats);
    end
  endtask

  task automatic test_no_match();
    valid_i = 1'b1; addr_i = 8'h40; mask_i = 8'h00; ready_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    tests++;
    if ({valid_o, idx_o, addr_o, mask_o, last_o, error_o} !== {1'b1, 2'd0, 8'h40, 8'h00, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL nomatch_beat: got v=%b idx=%0d addr=%h mask=%h last=%b err=%b, want 1 0 40 00 1 1",
               valid_o, idx_o, addr_o, mask_o, last_o, error_o);
    end
    tests++;
    if (select_o !== 4'b0000) begin
      fails++;
      $display("FAIL nomatch_select: got %b, want 0000", select_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({valid_o, error_o} !== 2'b00) begin
      fails++;
      $display("FAIL nomatch_end: got v=%b err=%b, want 0 0", valid_o, error_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    valid_i = 1'b1; addr_i = 8'h00; mask_i = 8'h30; ready_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    // Final multicast beat is now on the output; present the next request.
    valid_i = 1'b1; addr_i = 8'h85; mask_i = 8'h00;
    @(negedge clk);
    tests++;
    if ({idx_o, last_o, ready_o} !== {2'd2, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL b2b_accept: got idx=%0d last=%b rdy=%b, want 2 1 1", idx_o, last_o, ready_o);
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    tests++;
    if ({valid_o, idx_o, addr_o, mask_o, last_o, error_o} !== {1'b1, 2'd3, 8'h85, 8'h00, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL b2b_beat: got v=%b idx=%0d addr=%h mask=%h last=%b err=%b, want 1 3 85 00 1 0",
               valid_o, idx_o, addr_o, mask_o, last_o, error_o);
    end
    tests++;
    if (select_o !== 4'b1000) begin
      fails++;
      $display("FAIL b2b_select: got %b, want 1000", select_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (valid_o !== 1'b0) begin
      fails++;
      $display("FAIL b2b_end: got valid=%b, want 0", valid_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int extra = 0;
    valid_i = 1'b1; addr_i = 8'h00; mask_i = 8'h30; ready_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    // First beat taken; reset while a new request is also offered.
    rst_i   = 1'b1;
    valid_i = 1'b1; addr_i = 8'h15; mask_i = 8'h00;
    @(posedge clk); #1;
    rst_i   = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    tests++;
    if ({valid_o, ready_o, select_o} !== {1'b0, 1'b1, 4'b0000}) begin
      fails++;
      $display("FAIL rstmid_state: got v=%b r=%b sel=%b, want 0 1 0000", valid_o, ready_o, select_o);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (valid_o) extra++;
    end
    tests++;
    if (extra !== 0) begin
      fails++;
      $display("FAIL rstmid_beats: got %0d stray beats, want 0", extra);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    addr_map[0] = '{idx: 0, addr: 8'h00, mask: 8'h0F};
    addr_map[1] = '{idx: 1, addr: 8'h10, mask: 8'h0F};
    addr_map[2] = '{idx: 2, addr: 8'h20, mask: 8'h1F};
    addr_map[3] = '{idx: 3, addr: 8'h80, mask: 8'h7F};
    test_reset();
    test_unicast();
    test_multicast();
    test_backpressure();
    test_no_match();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
